echo_pipeline_sequencer: RTL
============================

// Module: echo_pipeline_sequencer
// PURPOSE
//   Per-sample controller for the echo-cancellation datapath. Once per sampling period it issues
//   enable pulses in order: 16b->double converter, lag generator, then either parameter
//   adaptation (ADAPT mode) or echo cancellation (CANCEL mode). Each stage's ready is awaited
//   before the next pulse. The chosen result is captured and the 16b output converter is enabled.
// PARAMETERS
//   CNT_W        13    width of sampling_cycle_counter
//   PULSE_CYC    2     enable pulse length in clk_operation cycles (>=1)
//   TIMEOUT_CYC  1024  max cycles in any WAIT state before abort (only with SEQ_TIMEOUT_EN)
// PORTS
//   clk_operation           in   1      clock; all logic on rising edge
//   rst                     in   1      synchronous reset, active-high
//   sampling_cycle_counter  in   CNT_W  free-running sample-period counter; ==0 starts a sample
//   adapt_mode              in   1      1=ADAPT path, 0=CANCEL path; latched at sample start
//   ready_conv              in   1      converter done (level)
//   ready_lag               in   1      lag generator done (level)
//   ready_adapt             in   1      para_approx done (level)
//   ready_cancel            in   1      echo_cancelation done (level)
//   e                       in   64     adaptation error (double)
//   signal_without_echo     in   64     cancelled signal (double)
//   en_conv/en_lag          out  1      stage enable pulses
//   en_adapt/en_cancel      out  1      stage enable pulses
//   en_out                  out  1      output-converter enable; sticky high after first result
//   double_out              out  64     captured result (e or signal_without_echo)
//   out_valid               out  1      one-cycle strobe when double_out updates
//   iteration               out  32     count of completed ADAPT samples, wraps at 2^32
//   busy                    out  1      high whenever state != IDLE
//   overrun                 out  1      sticky: counter==0 while busy
//   timeout_err             out  1      sticky: a WAIT state hit TIMEOUT_CYC
// BEHAVIOUR
//   - Reset: state=IDLE; all outputs 0 (double_out=64'h0, iteration=0). rst mid-sample aborts
//     the sample at once; no pulse is completed and nothing is captured.
//   - States: IDLE -> CONV_EN -> CONV_WAIT -> LAG_EN -> LAG_WAIT -> S3_EN -> S3_WAIT -> CAPTURE -> IDLE.
//     S3 is ADAPT or CANCEL, selected by mode_q.
//   - IDLE: if sampling_cycle_counter==0, latch mode_q<=adapt_mode and go to CONV_EN next cycle.
//     adapt_mode changes mid-sample are ignored.
//   - X_EN: the matching en_* is high for exactly PULSE_CYC cycles, then go to X_WAIT.
//     No two en_* are ever high together.
//   - Ready qualification: flag seen_low clears on X_EN entry. It sets if the stage ready is
//     low in any cycle of X_EN or X_WAIT. X_WAIT exits the first cycle ready==1 && seen_low.
//     A stale high ready therefore never completes a stage.
//   - CAPTURE (1 cycle): double_out<=mode_q ? e : signal_without_echo; out_valid=1; en_out<=1.
//     If mode_q, iteration<=iteration+1. Next state IDLE.
//   - Minimum latency start->out_valid: 3*PULSE_CYC + 3*2 + 2 cycles (ready toggles low/high
//     within 1 cycle each).
//   - counter==0 while busy: overrun<=1 and the current sample continues; no restart.
//     counter==0 in the CAPTURE cycle also counts as overrun. The next start needs a new
//     counter==0 seen in IDLE.
//   - Sticky flags clear only on rst.
// CONFIGURATION
//   SEQ_TIMEOUT_EN defined: each WAIT state runs a counter that clears on entry. If it reaches
//     TIMEOUT_CYC-1 without qualification, timeout_err<=1, state->IDLE, no capture and no
//     iteration change.
//   SEQ_TIMEOUT_EN undefined: WAIT states wait indefinitely; timeout_err tied 0; no counter logic.
// TESTING
//   1 rst=1 3 cycles -> all outputs 0, busy=0; release with counter!=0 -> stays IDLE.
//   2 ADAPT: counter->0, each ready drops 1 cycle after its pulse and rises 3 cycles later ->
//     en_conv,en_lag,en_adapt each 2-cycle pulses in order. Then out_valid=1,
//     double_out=e=64'h3FF0000000000000, iteration=1, en_out=1.
//   3 CANCEL: adapt_mode=0 at start, toggled to 1 mid-sample -> en_cancel (never en_adapt).
//     double_out=signal_without_echo, iteration unchanged.
//   4 ready_lag held high throughout, drops at cycle 10 of LAG_WAIT, rises at 12 ->
//     LAG_WAIT exits at cycle 12, not earlier.
//   5 counter wraps to 0 during S3_WAIT -> overrun=1; sample completes normally; next sample
//     starts only at the following counter==0.
//   6 SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, ready_adapt stuck 0 -> timeout_err=1 after 16 WAIT
//     cycles, IDLE, no out_valid; undefined build -> busy stays 1.

Source files
------------

// File: rtl/echo_pipeline_sequencer.sv
// Per-sample sequencer for the echo-cancellation datapath: conv -> lag -> adapt/cancel -> capture.
// Optional macro SEQ_TIMEOUT_EN adds a per-WAIT-state watchdog that aborts a stuck sample.
module echo_pipeline_sequencer #(
  parameter int CNT_W       = 13,
  parameter int PULSE_CYC   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk_operation,
  input  logic             rst,
  input  logic [CNT_W-1:0] sampling_cycle_counter,
  input  logic             adapt_mode,
  input  logic             ready_conv,
  input  logic             ready_lag,
  input  logic             ready_adapt,
  input  logic             ready_cancel,
  input  logic [63:0]      e,
  input  logic [63:0]      signal_without_echo,
  output logic             en_conv,
  output logic             en_lag,
  output logic             en_adapt,
  output logic             en_cancel,
  output logic             en_out,
  output logic [63:0]      double_out,
  output logic             out_valid,
  output logic [31:0]      iteration,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);
  localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  if (PULSE_CYC < 1) begin : g_bad_pulse
    $error("PULSE_CYC must be at least 1");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  // Encoding order matters: each EN/WAIT state advances to state+1.
  typedef enum logic [2:0] {
    IDLE, CONV_EN, CONV_WAIT, LAG_EN, LAG_WAIT, S3_EN, S3_WAIT, CAPTURE
  } state_t;

  state_t          state;
  logic            mode_q;
  logic            seen_low;
  logic [PW-1:0]   pcnt;
  logic            start;
  logic            in_stage;
  logic            stage_rdy;

  assign start    = (sampling_cycle_counter == '0);
  assign in_stage = (state != IDLE) && (state != CAPTURE);
  assign busy     = (state != IDLE);

  always_comb begin
    stage_rdy = 1'b0;
    case (state)
      CONV_EN, CONV_WAIT: stage_rdy = ready_conv;
      LAG_EN, LAG_WAIT:   stage_rdy = ready_lag;
      S3_EN, S3_WAIT:     stage_rdy = mode_q ? ready_adapt : ready_cancel;
      default:            stage_rdy = 1'b0;
    endcase
  end

`ifdef SEQ_TIMEOUT_EN
  logic [TW-1:0] wcnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      seen_low   <= 1'b0;
      pcnt       <= '0;
      en_conv    <= 1'b0;
      en_lag     <= 1'b0;
      en_adapt   <= 1'b0;
      en_cancel  <= 1'b0;
      en_out     <= 1'b0;
      double_out <= 64'h0;
      out_valid  <= 1'b0;
      iteration  <= 32'h0;
      overrun    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wcnt        <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (start && busy) overrun <= 1'b1;
      // A stage only counts as done after its ready has been seen low since the pulse began.
      if (in_stage && !stage_rdy) seen_low <= 1'b1;
      case (state)
        IDLE: if (start) begin
          mode_q   <= adapt_mode;
          en_conv  <= 1'b1;
          pcnt     <= '0;
          seen_low <= 1'b0;
          state    <= CONV_EN;
        end
        CONV_EN, LAG_EN, S3_EN: begin
          if (pcnt == PW'(PULSE_CYC - 1)) begin
            {en_conv, en_lag, en_adapt, en_cancel} <= 4'b0;
            state <= state_t'(state + 3'd1);
`ifdef SEQ_TIMEOUT_EN
            wcnt  <= '0;
`endif
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        CONV_WAIT, LAG_WAIT, S3_WAIT: begin
          if (stage_rdy && seen_low) begin
            pcnt     <= '0;
            seen_low <= 1'b0;
            state    <= state_t'(state + 3'd1);
            if (state == CONV_WAIT) en_lag <= 1'b1;
            if (state == LAG_WAIT) begin
              en_adapt  <= mode_q;
              en_cancel <= !mode_q;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wcnt == TW'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
`endif
        end
        CAPTURE: begin
          double_out <= mode_q ? e : signal_without_echo;
          out_valid  <= 1'b1;
          en_out     <= 1'b1;
          if (mode_q) iteration <= iteration + 32'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
